// File: rtl/mem_stage_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mem_stage_ctrl
//  Purpose  : Sequences the EX/MEM pipeline register and its data-SRAM port.
//             Holds the pipe during multi-cycle accesses, abandons hung
//             accesses after TIMEOUT_CYC wait cycles, and only lets flushes
//             and interrupt entry through on cycles where EX/MEM is not
//             stalled (EX/MEM ignores its flush input while stalled).
//  Revision : 1.0 - initial release
// ============================================================================
module mem_stage_ctrl #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_mem_op,
  input  logic i_mem_wr,
  input  logic i_sram_ack,
  input  logic i_irq,
  input  logic i_flush_req,
  output logic o_sram_req,
  output logic o_sram_we,
  output logic o_stall,
  output logic o_exmem_flush_n,
  output logic o_irq_take,
  output logic o_bus_err,
  output logic o_busy
);

  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_IRQ  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             we_q, we_d;
  logic             flush_pend_q, flush_pend_d;

  logic sram_req, sram_we, stall, irq_take, bus_err, flush_act;

  // State, wait counter, latched write flag and pending-flush register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  // Next-state and raw (pre-reset-gating) output decode
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    sram_req = 1'b0;
    sram_we  = 1'b0;
    stall    = 1'b0;
    irq_take = 1'b0;
    bus_err  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        sram_req = i_mem_op;
        sram_we  = i_mem_op & i_mem_wr;
        if (i_mem_op) begin
          // A pending access is always served before an interrupt is taken.
          if (!i_sram_ack) begin
            stall   = 1'b1;
            state_d = ST_WAIT;
            cnt_d   = '0;
            we_d    = i_mem_wr;
          end
        end else if (i_irq && !i_flush_req && !flush_pend_q) begin
          // A flush this cycle outranks interrupt entry; irq is level and
          // will be seen again next cycle.
          state_d = ST_IRQ;
        end
      end

      ST_WAIT: begin
        sram_req = 1'b1;
        sram_we  = we_q;
        cnt_d    = cnt_q + CNT_W'(1);
        if (i_sram_ack) begin
          // Completion beats the timeout when both land together.
          state_d = ST_IDLE;
        end else if (cnt_q == C_CNT_LAST) begin
          bus_err = 1'b1;
          state_d = ST_IDLE;
        end else begin
          stall = 1'b1;
        end
      end

      ST_IRQ: begin
        // Any MEM-stage op here is squashed by the flush: no SRAM strobe.
        irq_take = 1'b1;
        state_d  = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Flushes are held off while stalled and remembered until the pipe moves
  always_comb begin
    flush_act    = !stall && (i_flush_req || flush_pend_q || (state_q == ST_IRQ));
    flush_pend_d = flush_pend_q;
    if (stall && i_flush_req) begin
      flush_pend_d = 1'b1;
    end else if (!stall) begin
      flush_pend_d = 1'b0;
    end
  end

  // Reset forces the EX/MEM register to NOP and quiets everything else
  always_comb begin
    o_sram_req      = !i_rst && sram_req;
    o_sram_we       = !i_rst && sram_we;
    o_stall         = !i_rst && stall;
    o_exmem_flush_n = !i_rst && !flush_act;
    o_irq_take      = !i_rst && irq_take;
    o_bus_err       = !i_rst && bus_err;
    o_busy          = !i_rst && (state_q != ST_IDLE);
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_stage_ctrl
//  Purpose  : Directed self-checking bench for mem_stage_ctrl.
//             Output vector order: {req, we, stall, flush_n, irq_take,
//             bus_err, busy}.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_stage_ctrl;

  logic clk = 1'b0;
  logic rst, mem_op, mem_wr, ack, irq, flush_req;
  logic sram_req, sram_we, stall, flush_n, irq_take, bus_err, busy;
  logic [6:0] outv;

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  mem_stage_ctrl #(.TIMEOUT_CYC(16)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_mem_op       (mem_op),
    .i_mem_wr       (mem_wr),
    .i_sram_ack     (ack),
    .i_irq          (irq),
    .i_flush_req    (flush_req),
    .o_sram_req     (sram_req),
    .o_sram_we      (sram_we),
    .o_stall        (stall),
    .o_exmem_flush_n(flush_n),
    .o_irq_take     (irq_take),
    .o_bus_err      (bus_err),
    .o_busy         (busy)
  );

  assign outv = {sram_req, sram_we, stall, flush_n, irq_take, bus_err, busy};

  task automatic chk(input string tag, input logic [6:0] got, input logic [6:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %b expected %b (req we stall fln irqt berr busy)", tag, got, exp);
    end
  endtask

  // Apply inputs just after a rising edge; outputs are checked a few ns later
  task automatic drv(input logic op, input logic wr, input logic a,
                     input logic iq, input logic fl);
    mem_op = op; mem_wr = wr; ack = a; irq = iq; flush_req = fl;
    #3;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drv(0, 0, 0, 0, 0);
    cyc(); cyc();
    chk("reset_held", outv, 7'b0000000);
    rst = 1'b0;
    cyc();
    drv(0, 0, 0, 0, 0);
    chk("idle_after_reset", outv, 7'b0001000);

    // 1: zero-stall load
    drv(1, 0, 1, 0, 0);
    chk("t1_load_ack", outv, 7'b1001000);
    cyc(); drv(0, 0, 0, 0, 0);
    chk("t1_idle", outv, 7'b0001000);

    // 2: store, ack on third WAIT cycle
    drv(1, 1, 0, 0, 0);
    chk("t2_req", outv, 7'b1111000);
    cyc(); drv(1, 1, 0, 0, 0);
    chk("t2_w0", outv, 7'b1111001);
    cyc(); drv(1, 1, 0, 0, 0);
    chk("t2_w1", outv, 7'b1111001);
    cyc(); drv(1, 1, 1, 0, 0);
    chk("t2_ack", outv, 7'b1101001);
    cyc(); drv(0, 0, 0, 0, 0);
    chk("t2_idle", outv, 7'b0001000);

    // 3: load timeout after 16 WAIT cycles
    drv(1, 0, 0, 0, 0);
    chk("t3_req", outv, 7'b1011000);
    for (int i = 0; i < 15; i++) begin
      cyc(); drv(1, 0, 0, 0, 0);
      chk($sformatf("t3_w%0d", i), outv, 7'b1011001);
    end
    cyc(); drv(1, 0, 0, 0, 0);
    chk("t3_timeout", outv, 7'b1001011);
    cyc(); drv(0, 0, 0, 0, 0);
    chk("t3_after", outv, 7'b0001000);

    // 4: flush request during WAIT held until ack cycle
    drv(1, 0, 0, 0, 0);
    chk("t4_req", outv, 7'b1011000);
    cyc(); drv(1, 0, 0, 0, 0);
    chk("t4_w0", outv, 7'b1011001);
    cyc(); drv(1, 0, 0, 0, 1);
    chk("t4_w1_flreq", outv, 7'b1011001);
    cyc(); drv(1, 0, 0, 0, 0);
    chk("t4_w2_pend", outv, 7'b1011001);
    cyc(); drv(1, 0, 1, 0, 0);
    chk("t4_ack_flush", outv, 7'b1000001);
    cyc(); drv(0, 0, 0, 0, 0);
    chk("t4_pend_clr", outv, 7'b0001000);

    // Flush request with no stall applies at once
    drv(0, 0, 0, 0, 1);
    chk("idle_flush", outv, 7'b0000000);
    cyc(); drv(0, 0, 0, 0, 0);
    chk("idle_flush_done", outv, 7'b0001000);

    // 5: irq during WAIT deferred until after completion
    drv(1, 0, 0, 0, 0);
    chk("t5_req", outv, 7'b1011000);
    cyc(); drv(1, 0, 0, 1, 0);
    chk("t5_w0_irq", outv, 7'b1011001);
    cyc(); drv(1, 0, 1, 1, 0);
    chk("t5_ack", outv, 7'b1001001);
    cyc(); drv(0, 0, 0, 1, 0);
    chk("t5_idle_irq", outv, 7'b0001000);
    cyc(); drv(1, 1, 0, 1, 0);
    chk("t5_irq_take", outv, 7'b0000101);
    cyc(); drv(0, 0, 0, 0, 0);
    chk("t5_back_idle", outv, 7'b0001000);

    // Simultaneous irq and zero-stall access: access served, no irq entry
    drv(1, 0, 1, 1, 0);
    chk("irq_op_same", outv, 7'b1001000);
    cyc(); drv(0, 0, 0, 0, 0);
    chk("irq_op_after", outv, 7'b0001000);

    // Ack coincident with terminal count: no bus error
    drv(1, 0, 0, 0, 0);
    for (int i = 0; i < 15; i++) begin
      cyc(); drv(1, 0, 0, 0, 0);
    end
    chk("tc_w14", outv, 7'b1011001);
    cyc(); drv(1, 0, 1, 0, 0);
    chk("tc_ack_wins", outv, 7'b1001001);
    cyc(); drv(0, 0, 0, 0, 0);
    chk("tc_after", outv, 7'b0001000);

    // 6: reset in the middle of WAIT
    drv(1, 0, 0, 0, 0);
    cyc(); drv(1, 0, 0, 0, 0);
    chk("t6_w0", outv, 7'b1011001);
    rst = 1'b1;
    drv(1, 0, 0, 0, 0);
    chk("t6_rst_same", outv, 7'b0000000);
    cyc(); drv(1, 0, 0, 0, 0);
    chk("t6_rst_held", outv, 7'b0000000);
    rst = 1'b0;
    drv(0, 0, 0, 0, 0);
    chk("t6_idle", outv, 7'b0001000);
    cyc(); drv(0, 0, 0, 0, 0);
    chk("t6_no_berr", outv, 7'b0001000);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
Sequencing controller for the EX/MEM pipeline register and the data-SRAM port behind it.
- Drives the register's stall and active-low flush inputs.
- Holds the pipeline while a multi-cycle SRAM load/store is outstanding.
- Aborts hung accesses with a timeout.
- Admits interrupt and flush requests only at safe cycles, since EX/MEM ignores flush while stalled.

Parameters:
TIMEOUT_CYC, 16, cycles in WAIT without i_sram_ack before the access is abandoned (>=2)
CNT_W, $clog2(TIMEOUT_CYC), width of the wait counter (derived, not overridden)

Ports:
i_clk  input  1  system clock, rising edge
i_rst  input  1  reset, synchronous, active-high
i_mem_op  input  1  valid load/store in MEM stage (EX/MEM o_insn_vld & (o_ld_en!=0 | o_lsu_wren))
i_mem_wr  input  1  MEM-stage op is a store
i_sram_ack  input  1  SRAM completes current access this cycle
i_irq  input  1  level interrupt request from interrupt handler
i_flush_req  input  1  one-cycle request to flush EX/MEM (exception/redirect)
o_sram_req  output  1  SRAM access strobe
o_sram_we  output  1  SRAM write enable, valid with o_sram_req
o_stall  output  1  to EX/MEM i_stall and all upstream stage stalls
o_exmem_flush_n  output  1  to EX/MEM i_rst_n; low = load NOP (0x00000013)
o_irq_take  output  1  one-cycle pulse: interrupt accepted, PC redirect
o_bus_err  output  1  one-cycle pulse: access timed out
o_busy  output  1  state != IDLE

Behaviour:
States: IDLE, WAIT, IRQ_TAKE.
Reset (i_rst=1 at a clock edge):
- state=IDLE, counter=0, flush_pend=0.
- While i_rst is high: o_exmem_flush_n=0, o_stall=0, all other outputs 0.
IDLE:
- o_sram_req = o_sram_we&i_mem_wr... specifically o_sram_req=i_mem_op; o_sram_we=i_mem_op&i_mem_wr.
- i_mem_op & !i_sram_ack: o_stall=1 combinationally; next=WAIT; counter<=0.
- i_mem_op & i_sram_ack: zero-stall access; remain IDLE.
- Otherwise, i_irq: next=IRQ_TAKE.
WAIT:
- o_sram_req=1, o_stall=1, o_sram_we held from request cycle (registered copy).
- Counter increments each cycle.
- i_sram_ack: o_stall=0 that cycle; next=IDLE.
- counter==TIMEOUT_CYC-1 & !ack: o_bus_err=1, o_stall=0, next=IDLE.
- i_irq seen here is not taken; it remains level and is evaluated again in IDLE.
IRQ_TAKE (exactly one cycle):
- o_irq_take=1, o_exmem_flush_n=0, o_stall=0.
- next=IDLE.
- Any i_mem_op this cycle is squashed: no o_sram_req.
Flush rules:
- o_exmem_flush_n=0 whenever !o_stall & (i_flush_req | flush_pend | state==IRQ_TAKE).
- i_flush_req while o_stall=1 sets flush_pend; it is applied on the first non-stall cycle, then cleared.
- A flush is never asserted while o_stall=1.
Priority:
- Reset > in-flight access completion > flush > interrupt entry.
- Simultaneous i_irq and i_mem_op in IDLE: the access is served first; the interrupt is taken after completion.
- Simultaneous ack and timeout terminal count: ack wins, no o_bus_err.
Outputs:
- All outputs are combinational from state and inputs; state is registered.
- No combinational path from i_irq to o_stall.

Test Plan:
1. Load, ack in request cycle -> o_sram_req=1 for 1 cycle, o_stall never asserted, o_busy=0.
2. Store, ack after 3 cycles -> o_stall=1 for 3 cycles, o_sram_we=1 throughout, released in ack cycle, state IDLE next.
3. Load, no ack, TIMEOUT_CYC=16 -> o_stall high 16 cycles, o_bus_err pulse on 16th, stall released, o_bus_err=0 next cycle.
4. i_flush_req pulse during WAIT cycle 2, ack at cycle 4 -> o_exmem_flush_n=0 exactly in the ack cycle, not before; flush_pend cleared after.
5. i_irq raised during WAIT -> no o_irq_take until after ack. Then one IRQ_TAKE cycle: o_irq_take=1 and o_exmem_flush_n=0 together; o_sram_req=0 even if i_mem_op=1.
6. i_rst=1 mid-WAIT -> next cycle state IDLE, o_stall=0, o_exmem_flush_n=0 while reset held; no o_bus_err.
